regfile_dump_reader: RTL and testbench

Debug/test read-out engine that acts as the reader-side initiator toward the 32x32 register file. On a start pulse it drives the register file's combinational read-address port over a register index range and captures each value. It presents each value as one word on a valid/ready stream to a debug sink or testbench monitor, then reports a 32-bit additive checksum. It sits beside the datapath on one of the register file's read ports, selected by a debug mux outside this block.

---
 rtl/mips_pkg.sv | 12 +
 rtl/regfile_dump_reader.sv | 82 ++++++++
 tb/tb_regfile_dump_reader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file widths and dump reader state encoding
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } dump_state_t;
endpackage

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register index range, streams each captured value and reports its additive checksum
module regfile_dump_reader
  import mips_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] read_register,
  input  logic [DATA_W-1:0]     read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0]     out_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     checksum
);
  if (FIRST_REG < 0 || LAST_REG < FIRST_REG || LAST_REG > NUM_REGS - 1) begin : g_bad_range
    $error("regfile_dump_reader: register range %0d..%0d is invalid", FIRST_REG, LAST_REG);
  end
  localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(LAST_REG);
  dump_state_t state;
  logic [REG_ADDR_W-1:0] index;
  assign read_register = index;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      index <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      checksum <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          index <= FIRST_IDX;
          checksum <= '0;
          busy <= 1'b1;
          state <= READ;
        end
        READ: if (abort) begin
          busy <= 1'b0;
          state <= IDLE;
        end else begin
          out_data <= read_data;
          out_index <= index;
          out_valid <= 1'b1;
          state <= PRESENT;
        end
        PRESENT: if (abort) begin
          out_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end else if (out_ready) begin
          checksum <= checksum + out_data;
          out_valid <= 1'b0;
          // index stops at LAST_IDX, so a dump ending at 31 never wraps
          if (index == LAST_IDX) begin
            done <= 1'b1;
            state <= DONE;
          end else begin
            index <= index + 1'b1;
            state <= READ;
          end
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed and randomized dumps checked against a bench-side register file model
module tb_regfile_dump_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [4:0] read_register, out_index;
  logic [31:0] read_data, out_data, checksum;
  logic out_valid, busy, done;
  logic start1 = 1'b0;
  logic [4:0] read_register1, out_index1;
  logic [31:0] read_data1, out_data1, checksum1;
  logic out_valid1, busy1, done1;
  logic wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rf [32];
  logic [31:0] model [32];
  int tests = 0, failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;
  assign read_data = rf[read_register];
  assign read_data1 = rf[read_register1];

  regfile_dump_reader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .read_register(read_register), .read_data(read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_data(out_data),
    .busy(busy), .done(done), .checksum(checksum)
  );

  regfile_dump_reader #(.FIRST_REG(31), .LAST_REG(31)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(1'b0),
    .read_register(read_register1), .read_data(read_data1),
    .out_valid(out_valid1), .out_ready(1'b1), .out_index(out_index1), .out_data(out_data1),
    .busy(busy1), .done(done1), .checksum(checksum1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input int a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = 5'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic load_pattern();
    for (int k = 0; k < 32; k++) write_reg(k, k == 0 ? 32'h0 : 32'h100 + 32'(k));
  endtask

  // stop_idx >= 0 cuts the dump while that index is presented, by abort or by reset
  task automatic dump(input int bp, input int hold_idx, input int stop_idx, input bit use_abort, input bit cw);
    logic [31:0] exp [32];
    logic [31:0] sum;
    int idx, cyc, held, first_v;
    bit w5, w2;
    for (int k = 0; k < 32; k++) exp[k] = model[k];
    sum = 0; idx = 0; cyc = 0; held = 0; first_v = -1; w5 = 0; w2 = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_valid", 32'(out_valid), 0);
    chk("start_rr", 32'(read_register), 0);
    chk("start_sum", checksum, 0);
    while (idx < 32 && cyc < 1000) begin
      out_ready = ($urandom_range(99) >= bp);
      start = 1'(($urandom_range(1)));
      wr_en = 1'b0;
      chk("busy_mid", 32'(busy), 1);
      chk("done_early", 32'(done), 0);
      chk("sum_mid", checksum, sum);
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        if (idx == hold_idx && held < 5) begin
          out_ready = 1'b0;
          held++;
        end
        chk("word_index", 32'(out_index), 32'(idx));
        chk("word_data", out_data, exp[idx]);
        if (idx == stop_idx) begin
          out_ready = 1'b1;
          start = 1'b0;
          abort = use_abort;
          reset = !use_abort;
          tick();
          abort = 1'b0;
          reset = 1'b0;
          chk("stop_busy", 32'(busy), 0);
          chk("stop_valid", 32'(out_valid), 0);
          chk("stop_done", 32'(done), 0);
          chk("stop_sum", checksum, use_abort ? sum : 32'h0);
          if (!use_abort) begin
            chk("rst_index", 32'(out_index), 0);
            chk("rst_data", out_data, 0);
            chk("rst_rr", 32'(read_register), 0);
          end
          for (int k = 0; k < 3; k++) begin
            tick();
            chk("stop_no_done", 32'(done), 0);
          end
          return;
        end
      end
      if (cw && !w5 && !out_valid && read_register == 5'd5) begin
        w5 = 1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        model[5] = 32'hDEADBEEF;
      end else if (cw && !w2 && out_valid && out_index == 5'd2) begin
        w2 = 1;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hCAFEF00D;
        model[2] = 32'hCAFEF00D;
      end
      if (out_valid && out_ready) begin
        sum += exp[idx];
        idx++;
      end
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    chk("dump_complete", 32'(idx), 32);
    chk("first_valid_lat", 32'(first_v), 1);
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 1);
    chk("done_valid", 32'(out_valid), 0);
    chk("done_sum", checksum, sum);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("sum_hold", checksum, sum);
    tick();
    chk("no_restart", 32'(busy), 0);
  endtask

  initial begin
    tick(); tick();
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_sum", checksum, 0);
    chk("reset_index", 32'(out_index), 0);
    chk("reset_data", out_data, 0);
    chk("reset_rr", 32'(read_register), 0);
    reset = 1'b0;
    load_pattern();
    begin : single
      int n;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 20) begin tick(); n++; end
      chk("single_index", 32'(out_index1), 31);
      chk("single_data", out_data1, model[31]);
      tick();
      chk("single_done", 32'(done1), 1);
      chk("single_sum", checksum1, model[31]);
      tick();
      chk("single_idle", 32'(busy1), 0);
    end
    dump(0, -1, -1, 0, 0);
    dump(0, 3, -1, 0, 0);
    write_reg(6, 32'h66666666);
    dump(0, -1, -1, 0, 1);
    chk("r5_written_after", model[5], rf[5]);
    load_pattern();
    dump(0, -1, 10, 0, 0);
    dump(0, -1, -1, 0, 0);
    dump(0, -1, 7, 1, 0);
    dump(30, -1, -1, 0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 32; k++) write_reg(k, $urandom);
      dump($urandom_range(70), $urandom_range(31), r[0] ? int'($urandom_range(31)) : -1, 1'($urandom_range(1)), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
